iadc_conv_ctrl: RTL and testbench

Conversion sequencer for the incremental ADC. It runs each conversion in order: resets the modulator and the decimation filter, holds them in integration for exactly OSR bitstream samples, waits for the filter pipeline to drain, then captures the filter output into a result register and pulses done. It sits between the host/register interface and the digital_filter + modulator pair, and owns their reset lines.

---
 rtl/iadc_conv_ctrl.sv | 141 ++++++++++++++
 tb/tb_iadc_conv_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iadc_conv_ctrl.sv
// Conversion sequencer for the incremental ADC: reset, OSR-sample integration, drain, capture.
// Optional `CONT_CONV_EN adds the cont input for back-to-back conversions.
module iadc_conv_ctrl #(
    parameter int OSR           = 512,
    parameter int RST_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int DW            = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
`ifdef CONT_CONV_EN
    input  logic          cont,
`endif
    input  logic [DW-1:0] filt_data,
    output logic          filt_rst_n,
    output logic          mod_rst_n,
    output logic          sample_en,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result
);

    localparam int CNT_MAX = (OSR > RST_CYCLES)
                           ? ((OSR > SETTLE_CYCLES) ? OSR : SETTLE_CYCLES)
                           : ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES);
    localparam int CW = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_INTEG,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
`ifdef CONT_CONV_EN
    logic          restart;
`endif

    // NOTE: all state and outputs are updated with non-blocking assignments so every
    // register samples pre-edge values; result is reset too, since a reset must wipe it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            filt_rst_n <= 1'b0;
            mod_rst_n  <= 1'b0;
            sample_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
`ifdef CONT_CONV_EN
            restart    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state      <= S_IDLE;
                cnt        <= '0;
                filt_rst_n <= 1'b0;
                mod_rst_n  <= 1'b0;
                sample_en  <= 1'b0;
                busy       <= 1'b0;
`ifdef CONT_CONV_EN
                restart    <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_RST;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    S_RST: begin
`ifdef CONT_CONV_EN
                        // A chained conversion spends the done cycle as one extra reset cycle.
                        if (restart) restart <= 1'b0;
                        else
`endif
                        if (int'(cnt) == RST_CYCLES - 1) begin
                            state      <= S_INTEG;
                            cnt        <= '0;
                            filt_rst_n <= 1'b1;
                            mod_rst_n  <= 1'b1;
                            sample_en  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_INTEG: begin
                        if (int'(cnt) == OSR - 1) begin
                            cnt       <= '0;
                            mod_rst_n <= 1'b0;
                            sample_en <= 1'b0;
                            state     <= (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (int'(cnt) == SETTLE_CYCLES - 1) begin
                            state <= S_CAPTURE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        result     <= filt_data;
                        done       <= 1'b1;
                        filt_rst_n <= 1'b0;
                        cnt        <= '0;
`ifdef CONT_CONV_EN
                        if (cont) begin
                            state   <= S_RST;
                            restart <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= S_IDLE;
                        busy  <= 1'b0;
`endif
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iadc_conv_ctrl.sv
// Self-checking bench for iadc_conv_ctrl: random bitstream, stand-in double-integrator filter,
// closed-form reference for each result. Define CONT_CONV_EN to also exercise continuous mode.
module tb_iadc_conv_ctrl;

    localparam int OSR    = 512;
    localparam int RSTC   = 2;
    localparam int SETTLE = 2;
    localparam int DW     = 12;
    localparam int LAT    = 1 + RSTC + OSR + SETTLE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
`ifdef CONT_CONV_EN
    logic          cont = 1'b0;
`endif
    logic [DW-1:0] filt_data;
    logic          filt_rst_n, mod_rst_n, sample_en, busy, done;
    logic [DW-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    int done_total = 0;

    bit zero_bits = 1'b1;
    bit bs = 1'b0;
    bit bits [1024];
    int nbits = 0;
    logic [31:0] acc1 = '0;
    logic [31:0] acc2 = '0;

    iadc_conv_ctrl #(.OSR(OSR), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETTLE), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
`ifdef CONT_CONV_EN
        .cont(cont),
`endif
        .filt_data(filt_data),
        .filt_rst_n(filt_rst_n),
        .mod_rst_n(mod_rst_n),
        .sample_en(sample_en),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Modulator model: random bit per cycle, forced to 0 while held in reset.
    always @(negedge clk) bs = (mod_rst_n === 1'b1 && !zero_bits) ? 1'($urandom_range(0, 1)) : 1'b0;

    // Stand-in digital_filter: two cascaded integrators, output scaled by >>6.
    always @(posedge clk) begin
        if (filt_rst_n !== 1'b1) begin
            acc1 <= '0;
            acc2 <= '0;
        end else begin
            acc1 <= acc1 + 32'(bs);
            acc2 <= acc2 + acc1;
        end
    end
    assign filt_data = DW'(acc2 >> 6);

    // Record the bits the modulator emitted inside the integration window.
    always @(posedge clk) begin
        if (mod_rst_n === 1'b1) begin
            if (nbits < 1024) bits[nbits] = bs;
            nbits++;
        end else if (filt_rst_n !== 1'b1) begin
            nbits = 0;
        end
    end

    always @(negedge clk) if (done === 1'b1) done_total++;

    // Bit i is integrated once by the first stage, then summed by the second stage on every
    // remaining filter update: OSR+SETTLE-1-i times in total.
    function automatic logic [DW-1:0] ref_result();
        int sum = 0;
        for (int i = 0; i < nbits && i < 1024; i++)
            if (bits[i]) sum += OSR + SETTLE - 1 - i;
        return DW'(sum >> 6);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One conversion from its start edge to the done cycle; optional start re-pulses mid-run,
    // and optional start raised in the done cycle to chain the next conversion.
    task automatic run_conv(input bit prestarted, input bit repulse, input bit chain);
        int se = 0, fr = 0, gaps = 0, lat = -1;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (repulse && (n == 5 || n == 300 || n == 516)) start = 1'b1;
            if (n == 0) check("started_busy", 32'(busy), 1);
            if (done === 1'b1) begin
                lat = n;
                if (chain) start = 1'b1;
                break;
            end
            if (sample_en === 1'b1) se++;
            if (filt_rst_n === 1'b1) fr++;
            if (busy !== 1'b1) gaps++;
        end
        check("done_latency", 32'(lat), 32'(LAT));
        check("sample_en_cycles", 32'(se), 32'(OSR));
        check("filt_rst_n_cycles", 32'(fr), 32'(OSR + SETTLE + 1));
        check("busy_gaps", 32'(gaps), 0);
        check("samples_taken", 32'(nbits), 32'(OSR));
        check("result", 32'(result), 32'(ref_result()));
    endtask

    initial begin
        int d0;
        logic [DW-1:0] r0;
        int cnt;

        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sample_en", 32'(sample_en), 0);
        check("rst_filt_rst_n", 32'(filt_rst_n), 0);
        check("rst_mod_rst_n", 32'(mod_rst_n), 0);
        check("rst_result", 32'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // All-zero bitstream with ignored re-pulses, then a start in the done cycle.
        d0 = done_total;
        zero_bits = 1'b1;
        run_conv(1'b0, 1'b1, 1'b1);
        check("zero_result", 32'(result), 0);
        zero_bits = 1'b0;
        run_conv(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("done_count_chain", 32'(done_total - d0), 2);
        check("done_width", 32'(done), 0);

        // Random conversions against the reference.
        for (int c = 0; c < 9; c++) begin
            d0 = done_total;
            run_conv(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check("done_count", 32'(done_total - d0), 1);
            check("idle_busy", 32'(busy), 0);
        end

        // Abort at sample 200.
        d0 = done_total;
        r0 = result;
        cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (sample_en === 1'b1) cnt++;
            if (cnt == 200) begin
                abort = 1'b1;
                break;
            end
        end
        check("abort_reached", 32'(cnt), 200);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_sample_en", 32'(sample_en), 0);
        check("abort_filt_rst_n", 32'(filt_rst_n), 0);
        check("abort_mod_rst_n", 32'(mod_rst_n), 0);
        repeat (600) @(negedge clk);
        check("abort_no_done", 32'(done_total - d0), 0);
        check("abort_result_kept", 32'(result), 32'(r0));
        run_conv(1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges, mid-integration.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_sample_en", 32'(sample_en), 0);
        check("arst_filt_rst_n", 32'(filt_rst_n), 0);
        check("arst_mod_rst_n", 32'(mod_rst_n), 0);
        check("arst_done", 32'(done), 0);
        check("arst_result", 32'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_conv(1'b0, 1'b0, 1'b0);

`ifdef CONT_CONV_EN
        begin
            int last = -1, seen = 0, gaps = 0;
            cont = 1'b1;
            d0 = done_total;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            for (int n = 0; n < 3000 && seen < 4; n++) begin
                @(negedge clk);
                start = 1'b0;
                if (busy !== 1'b1) gaps++;
                if (done === 1'b1) begin
                    check("cont_result", 32'(result), 32'(ref_result()));
                    if (seen > 0) check("cont_period", 32'(n - last), 32'(LAT + 1));
                    last = n;
                    seen++;
                    if (seen == 3) cont = 1'b0;
                end
            end
            check("cont_dones", 32'(seen), 4);
            check("cont_busy_gaps", 32'(gaps), 0);
            repeat (600) @(negedge clk);
            check("cont_stop_dones", 32'(done_total - d0), 4);
            check("cont_stop_busy", 32'(busy), 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
